// File: rtl/game_scoreboard_pkg.sv
// Shared types for the game scoreboard: FSM state encoding and "who reached the limit" codes.
package game_pkg;

    typedef enum logic [1:0] {
        PLAY     = 2'b00,
        OVER     = 2'b01,
        CLEARING = 2'b10
    } state_e;

    localparam logic [1:0] WHO_NONE   = 2'b00;
    localparam logic [1:0] WHO_LOSER  = 2'b01;
    localparam logic [1:0] WHO_WINNER = 2'b10;
    localparam logic [1:0] WHO_TIE    = 2'b11;

endpackage

// File: rtl/game_scoreboard_rise_detect.sv
// One-bit rising-edge detector; priming forces the history to 1 so a level that is
// already high when priming ends never looks like a fresh edge.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic prime,
    input  logic d,
    output logic rise
);

    logic d_q;

    always_ff @(posedge clk) begin
        if (!rst || prime) begin
            d_q <= 1'b1;
        end else begin
            d_q <= d;
        end
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/game_scoreboard.sv
// Tallies fresh win/lose edges from the up/down counter, flags game-over at LIMIT and
// holds counter_clear high for CLR_CYCLES cycles so the next game starts by itself.
module game_scoreboard
    import game_pkg::*;
#(
    parameter int SCORE_W    = 4,
    parameter int LIMIT      = 15,
    parameter int CLR_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               winner,
    input  logic               loser,
    output logic [SCORE_W-1:0] win_count,
    output logic [SCORE_W-1:0] lose_count,
    output logic               gameover,
    output logic [1:0]         who,
    output logic               counter_clear
);

    localparam int CNT_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

    state_e             state;
    logic [CNT_W-1:0]   clr_left;
    logic               win_evt;
    logic               lose_evt;
    logic               prime;
    logic [SCORE_W-1:0] win_nxt;
    logic [SCORE_W-1:0] lose_nxt;
    logic               win_hit;
    logic               lose_hit;

    // counter_clear is high exactly while the upstream counter is being cleared,
    // which is when the edge history must be held at 1.
    assign prime = clear | counter_clear;

    rise_detect u_win_edge (
        .clk   (clk),
        .rst   (rst),
        .prime (prime),
        .d     (winner),
        .rise  (win_evt)
    );

    rise_detect u_lose_edge (
        .clk   (clk),
        .rst   (rst),
        .prime (prime),
        .d     (loser),
        .rise  (lose_evt)
    );

    // Tallies are always below LIMIT while playing, so +1 cannot wrap.
    assign win_nxt  = win_count + SCORE_W'(win_evt);
    assign lose_nxt = lose_count + SCORE_W'(lose_evt);
    assign win_hit  = win_evt && (win_nxt == SCORE_W'(LIMIT));
    assign lose_hit = lose_evt && (lose_nxt == SCORE_W'(LIMIT));

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            state         <= PLAY;
            clr_left      <= '0;
            win_count     <= '0;
            lose_count    <= '0;
            gameover      <= 1'b0;
            who           <= WHO_NONE;
            counter_clear <= 1'b0;
        end else begin
            case (state)
                PLAY: begin
                    gameover <= 1'b0;
                    if (counter_clear) begin
                        // Only reachable with CLR_CYCLES == 1: finish the clear here.
                        counter_clear <= 1'b0;
                        win_count     <= '0;
                        lose_count    <= '0;
                    end else begin
                        win_count  <= win_nxt;
                        lose_count <= lose_nxt;
                        if (win_hit || lose_hit) begin
                            gameover <= 1'b1;
                            who      <= win_hit ? (lose_hit ? WHO_TIE : WHO_WINNER) : WHO_LOSER;
                            state    <= OVER;
                        end
                    end
                end
                OVER: begin
                    gameover      <= 1'b0;
                    counter_clear <= 1'b1;
                    clr_left      <= CNT_W'(CLR_CYCLES - 1);
                    state         <= (CLR_CYCLES == 1) ? PLAY : CLEARING;
                end
                CLEARING: begin
                    if (clr_left == '0) begin
                        counter_clear <= 1'b0;
                        win_count     <= '0;
                        lose_count    <= '0;
                        state         <= PLAY;
                    end else begin
                        clr_left <= clr_left - CNT_W'(1);
                    end
                end
                default: state <= PLAY;
            endcase
        end
    end

endmodule
